// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bundle for the pipelined carry-lookahead adder/subtractor.
// Handshake: valid-only, no backpressure. The slave takes A/B/Cin/Sub on every rising edge
// where En=1 and InValid=1. Results are qualified by OutValid. En=0 freezes the whole pipe,
// so an InValid raised while En=0 is not taken.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             En;
  logic             InValid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             OutValid;

  modport master (
    output En, InValid, A, B, Cin, Sub,
    input  Sum, Cout, Ovf, OutValid
  );

  modport slave (
    input  En, InValid, A, B, Cin, Sub,
    output Sum, Cout, Ovf, OutValid
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Fully pipelined carry-lookahead adder/subtractor. One lookahead group resolves per stage,
// and the group carry is registered between stages. Latency is NG = WIDTH/GROUP cycles.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                  Clk,
  input  logic                  Rs,
  pipelined_cla_adder_if.slave  io
);
  localparam int NG = WIDTH / GROUP;

  // Level s holds the state leaving stage s. Operand bits of later groups ride along as
  // skew, and sum bits of earlier groups ride along as deskew.
  logic [WIDTH-1:0] a_q   [NG];
  logic [WIDTH-1:0] a_d   [NG];
  logic [WIDTH-1:0] b_q   [NG];
  logic [WIDTH-1:0] b_d   [NG];
  logic [WIDTH-1:0] sum_q [NG];
  logic [WIDTH-1:0] sum_d [NG];
  logic [NG-1:0]    c_q, c_d;
  logic [NG-1:0]    v_q, v_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] stg_a, stg_b, stg_sum;
  logic             stg_c, stg_v, upd, term, cl;
  logic [GROUP-1:0] g, p;
  logic [GROUP:0]   cy;
  int               sp;

  always_comb begin
    stg_a   = '0;
    stg_b   = '0;
    stg_sum = '0;
    stg_c   = 1'b0;
    stg_v   = 1'b0;
    upd     = 1'b0;
    term    = 1'b0;
    cl      = 1'b0;
    g       = '0;
    p       = '0;
    cy      = '0;
    sp      = 0;
    ovf_d   = ovf_q;
    c_d     = c_q;
    v_d     = v_q;
    for (int s = 0; s < NG; s++) begin
      a_d[s]   = a_q[s];
      b_d[s]   = b_q[s];
      sum_d[s] = sum_q[s];
    end

    for (int s = 0; s < NG; s++) begin
      sp = (s > 0) ? s - 1 : 0;
      if (s == 0) begin
        stg_a   = io.A;
        stg_b   = io.B ^ {WIDTH{io.Sub}};
        stg_c   = io.Sub | io.Cin;
        stg_sum = '0;
        stg_v   = io.InValid;
      end else begin
        stg_a   = a_q[sp];
        stg_b   = b_q[sp];
        stg_c   = c_q[sp];
        stg_sum = sum_q[sp];
        stg_v   = v_q[sp];
      end

      for (int i = 0; i < GROUP; i++) begin
        g[i] = stg_a[s*GROUP + i] & stg_b[s*GROUP + i];
        p[i] = stg_a[s*GROUP + i] ^ stg_b[s*GROUP + i];
      end

      // Each internal carry is a flat sum of products over g/p and the group carry-in.
      cy[0] = stg_c;
      for (int i = 0; i < GROUP; i++) begin
        cl = stg_c;
        for (int m = 0; m <= i; m++) cl = cl & p[m];
        for (int j = 0; j <= i; j++) begin
          term = g[j];
          for (int m = j + 1; m <= i; m++) term = term & p[m];
          cl = cl | term;
        end
        cy[i+1] = cl;
      end

      stg_sum[s*GROUP +: GROUP] = p ^ cy[GROUP-1:0];

      // Data only moves with a valid token, so outputs hold the last result across bubbles.
      upd = io.En & stg_v;
      if (upd) begin
        a_d[s]   = stg_a;
        b_d[s]   = stg_b;
        sum_d[s] = stg_sum;
        c_d[s]   = cy[GROUP];
        if (s == NG - 1) ovf_d = cy[GROUP] ^ cy[GROUP-1];
      end
      if (io.En) v_d[s] = stg_v;
    end
  end

  always_ff @(posedge Clk or posedge Rs) begin
    if (Rs) begin
      for (int s = 0; s < NG; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int s = 0; s < NG; s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign io.Sum      = sum_q[NG-1];
  assign io.Cout     = c_q[NG-1];
  assign io.Ovf      = ovf_q;
  assign io.OutValid = v_q[NG-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder with WIDTH=16 and GROUP=4, giving a 4-cycle latency.
// Inputs are driven #1 after each rising edge, and outputs are sampled at the same point.
module tb_pipelined_cla_adder;
  localparam int W = 16;

  logic Clk;
  logic Rs;
  int   tests_run    = 0;
  int   tests_failed = 0;

  pipelined_cla_adder_if #(.WIDTH(W)) io ();

  pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
    .Clk (Clk),
    .Rs  (Rs),
    .io  (io.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    io.InValid = 1'b0;
    io.A       = '0;
    io.B       = '0;
    io.Cin     = 1'b0;
    io.Sub     = 1'b0;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    io.InValid = 1'b1;
    io.A       = a;
    io.B       = b;
    io.Cin     = cin;
    io.Sub     = sub;
  endtask

  task automatic test_reset();
    Rs    = 1'b1;
    io.En = 1'b1;
    idle_inputs();
    step();
    set_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    step();
    step();
    tests_run++;
    if (io.Sum !== 16'h0000) begin tests_failed++; $display("FAIL reset_sum: got %h expected %h", io.Sum, 16'h0000); end
    tests_run++;
    if (io.Cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout: got %b expected 0", io.Cout); end
    tests_run++;
    if (io.Ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", io.Ovf); end
    tests_run++;
    if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL reset_outvalid: got %b expected 0", io.OutValid); end
    Rs = 1'b0;
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL reset_release_outvalid c%0d: got %b expected 0", c, io.OutValid); end
    end
  endtask

  task automatic test_carry_chain();
    set_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    step();
    idle_inputs();
    for (int c = 1; c < 4; c++) begin
      tests_run++;
      if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL carry_early_valid cycle %0d: got %b expected 0", c, io.OutValid); end
      step();
    end
    tests_run++;
    if (io.OutValid !== 1'b1) begin tests_failed++; $display("FAIL carry_outvalid: got %b expected 1", io.OutValid); end
    tests_run++;
    if (io.Sum !== 16'h0000) begin tests_failed++; $display("FAIL carry_sum: got %h expected %h", io.Sum, 16'h0000); end
    tests_run++;
    if (io.Cout !== 1'b1) begin tests_failed++; $display("FAIL carry_cout: got %b expected 1", io.Cout); end
    tests_run++;
    if (io.Ovf !== 1'b0) begin tests_failed++; $display("FAIL carry_ovf: got %b expected 0", io.Ovf); end
    step();
    tests_run++;
    if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL carry_after_valid: got %b expected 0", io.OutValid); end
  endtask

  task automatic test_overflow();
    set_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    step();
    idle_inputs();
    step(); step(); step();
    tests_run++;
    if (io.OutValid !== 1'b1) begin tests_failed++; $display("FAIL ovf_outvalid: got %b expected 1", io.OutValid); end
    tests_run++;
    if (io.Sum !== 16'h8000) begin tests_failed++; $display("FAIL ovf_sum: got %h expected %h", io.Sum, 16'h8000); end
    tests_run++;
    if (io.Cout !== 1'b0) begin tests_failed++; $display("FAIL ovf_cout: got %b expected 0", io.Cout); end
    tests_run++;
    if (io.Ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_ovf: got %b expected 1", io.Ovf); end
    step();
  endtask

  task automatic test_subtract();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    logic [W-1:0] es [2];
    logic         ec [2];
    logic         eo [2];
    ta = '{16'h0005, 16'h8000};
    tb = '{16'h0007, 16'h0001};
    es = '{16'hFFFE, 16'h7FFF};
    ec = '{1'b0, 1'b1};
    eo = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      set_op(ta[k], tb[k], 1'b1, 1'b1);
      step();
      idle_inputs();
      step(); step(); step();
      tests_run++;
      if (io.OutValid !== 1'b1) begin tests_failed++; $display("FAIL sub%0d_outvalid: got %b expected 1", k, io.OutValid); end
      tests_run++;
      if (io.Sum !== es[k]) begin tests_failed++; $display("FAIL sub%0d_sum: got %h expected %h", k, io.Sum, es[k]); end
      tests_run++;
      if (io.Cout !== ec[k]) begin tests_failed++; $display("FAIL sub%0d_cout: got %b expected %b", k, io.Cout, ec[k]); end
      tests_run++;
      if (io.Ovf !== eo[k]) begin tests_failed++; $display("FAIL sub%0d_ovf: got %b expected %b", k, io.Ovf, eo[k]); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic         tc [4];
    logic [W-1:0] es [4];
    logic         ec [4];
    ta = '{16'h1234, 16'h00FF, 16'hABCD, 16'h0000};
    tb = '{16'h1111, 16'h0001, 16'h5433, 16'h0000};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1};
    es = '{16'h2345, 16'h0100, 16'h0000, 16'h0001};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      set_op(ta[k], tb[k], tc[k], 1'b0);
      step();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (io.OutValid !== 1'b1) begin tests_failed++; $display("FAIL b2b%0d_outvalid: got %b expected 1", k, io.OutValid); end
      tests_run++;
      if (io.Sum !== es[k]) begin tests_failed++; $display("FAIL b2b%0d_sum: got %h expected %h", k, io.Sum, es[k]); end
      tests_run++;
      if (io.Cout !== ec[k]) begin tests_failed++; $display("FAIL b2b%0d_cout: got %b expected %b", k, io.Cout, ec[k]); end
      tests_run++;
      if (io.Ovf !== 1'b0) begin tests_failed++; $display("FAIL b2b%0d_ovf: got %b expected 0", k, io.Ovf); end
      step();
    end
    tests_run++;
    if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL b2b_tail_valid: got %b expected 0", io.OutValid); end
  endtask

  task automatic test_stall();
    set_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    step();
    // Offered while stalled, so it must never be taken.
    set_op(16'h4444, 16'h4444, 1'b0, 1'b0);
    io.En = 1'b0;
    step();
    tests_run++;
    if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL stall_valid c2: got %b expected 0", io.OutValid); end
    step();
    tests_run++;
    if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL stall_valid c3: got %b expected 0", io.OutValid); end
    io.En = 1'b1;
    idle_inputs();
    step();
    step();
    tests_run++;
    if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL stall_early c5: got %b expected 0", io.OutValid); end
    step();
    tests_run++;
    if (io.OutValid !== 1'b1) begin tests_failed++; $display("FAIL stall_outvalid c6: got %b expected 1", io.OutValid); end
    tests_run++;
    if (io.Sum !== 16'h0100) begin tests_failed++; $display("FAIL stall_sum: got %h expected %h", io.Sum, 16'h0100); end
    tests_run++;
    if (io.Cout !== 1'b0) begin tests_failed++; $display("FAIL stall_cout: got %b expected 0", io.Cout); end
    step();
    tests_run++;
    if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL stall_ghost c7: got %b expected 0", io.OutValid); end
    step();
  endtask

  task automatic test_reset_mid_flight();
    set_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    step();
    set_op(16'h0002, 16'h0002, 1'b0, 1'b0);
    step();
    set_op(16'h0003, 16'h0003, 1'b0, 1'b0);
    Rs = 1'b1;
    #1;
    tests_run++;
    if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_async_valid: got %b expected 0", io.OutValid); end
    tests_run++;
    if (io.Sum !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_async_sum: got %h expected %h", io.Sum, 16'h0000); end
    step();
    Rs = 1'b0;
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      tests_run++;
      if (io.OutValid !== 1'b0 || io.Sum !== 16'h0000) begin
        tests_failed++;
        $display("FAIL rstmid_drain c%0d: got valid=%b sum=%h expected valid=0 sum=0000", c, io.OutValid, io.Sum);
      end
      step();
    end
    set_op(16'h0102, 16'h0304, 1'b1, 1'b0);
    step();
    idle_inputs();
    for (int c = 1; c < 4; c++) begin
      tests_run++;
      if (io.OutValid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_early c%0d: got %b expected 0", c, io.OutValid); end
      step();
    end
    tests_run++;
    if (io.OutValid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_outvalid: got %b expected 1", io.OutValid); end
    tests_run++;
    if (io.Sum !== 16'h0407) begin tests_failed++; $display("FAIL rstmid_sum: got %h expected %h", io.Sum, 16'h0407); end
    step();
  endtask

  initial begin
    Rs    = 1'b1;
    io.En = 1'b1;
    idle_inputs();
    test_reset();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_stall();
    test_reset_mid_flight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, fully pipelined carry-lookahead adder/subtractor.
- The operand is split into WIDTH/GROUP lookahead groups. Each group resolves in its own pipeline stage, and the carry between groups is registered.
- Accepts one operation per clock and raises a signed-overflow flag.
- Successor to the fixed 4-bit registered-carry CLA, for datapaths wider than 4 bits and for throughput-critical arithmetic.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be an integer multiple of GROUP.
- GROUP, 4, bits per lookahead group. Legal range 1..8.
- NG (localparam), WIDTH/GROUP, number of groups. Also equals the pipeline latency.

Ports:
- Clk  in  1  clock. All state updates on the rising edge.
- Rs  in  1  reset. Asynchronous, active-high.
- En  in  1  pipeline enable. 0 freezes every register in the block.
- InValid  in  1  A/B/Cin/Sub are valid this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in. Ignored when Sub=1.
- Sub  in  1  0 computes A+B+Cin. 1 computes A-B, as A+~B+1.
- Sum  out  WIDTH  result.
- Cout  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- Ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- OutValid  out  1  Sum/Cout/Ovf are valid.

Behaviour:
- Reset:
  - Rs=1 asynchronously clears all stage, skew and deskew registers.
  - Sum=0, Cout=0, Ovf=0, OutValid=0 while Rs is high and until the first valid result after release.
  - Operations in flight are discarded.
- Operand conditioning at acceptance:
  - Effective B is B^{WIDTH{Sub}}.
  - Group-0 carry-in is Sub ? 1 : Cin.
- Stage k (k=0..NG-1):
  - Computes per-bit generate and propagate for group k.
  - Computes the group's internal carries by lookahead, not by ripple.
  - Computes the group sum bits and the group carry-out from the carry registered by stage k-1 (stage 0 uses the conditioned carry-in).
  - Registers the group carry-out for stage k+1.
- Input skew: operand bits of group k travel through k skew registers, so each group meets its carry in the same cycle.
- Output deskew:
  - Sum bits of group k are delayed NG-1-k registers so all groups emerge aligned.
  - Sum, Cout and Ovf are driven from registers.
  - Ovf uses the carry into bit WIDTH-1, registered alongside the final stage.
- Valid: a NG-deep shift register carries InValid. OutValid is its last stage.
- Latency and throughput:
  - With En held high, a result appears exactly NG cycles after its InValid cycle (GROUP=4, WIDTH=16 gives 4 cycles).
  - Throughput is one operation per cycle with no bubbles.
- En=0:
  - No register updates, including the valid pipe.
  - Outputs hold their last values, and InValid that cycle is not accepted.
  - Latency is extended by the number of En=0 cycles.
- InValid=0 with En=1:
  - A bubble enters the pipe, and data registers may still update.
  - OutValid=0 for that slot, and Sum/Cout/Ovf are don't-care when OutValid=0.
- Wrap-around: the sum is modulo 2^WIDTH, and Cout carries the lost bit.
- Degenerate case GROUP=WIDTH (NG=1): single stage, latency 1, no skew registers.
- Simultaneous Rs and En/InValid: Rs dominates.

Test Plan (WIDTH=16, GROUP=4, En=1 unless stated):
- Carry through all groups: A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> 4 cycles later OutValid=1, Sum=0x0000, Cout=1, Ovf=0.
- Signed overflow: A=0x7FFF, B=0x0001, Sub=0 -> Sum=0x8000, Cout=0, Ovf=1.
- Subtract with borrow: A=0x0005, B=0x0007, Sub=1, Cin=1 (must be ignored) -> Sum=0xFFFE, Cout=0, Ovf=0. Then A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, Cout=1, Ovf=1.
- Back-to-back: four ops on consecutive cycles, (0x1234+0x1111), (0x00FF+0x0001), (0xABCD+0x5433, Cin=0), (0x0000+0x0000, Cin=1) -> results 0x2345, 0x0100, 0x0000 with Cout=1, and 0x0001, on four consecutive cycles starting at cycle 4, each with OutValid=1.
- Stall: accept 0x00FF+0x0001, drop En for 2 cycles after 1 cycle in flight -> result 0x0100 appears at cycle 6. Outputs and OutValid are unchanged during the stall.
- Reset mid-flight: issue 3 ops, assert Rs for 1 cycle at cycle 2 -> OutValid goes 0 immediately, no result from the 3 ops ever appears, and Sum=0. The next op after release emerges 4 cycles after its InValid.
